stage_if: RTL and testbench
===========================

// Module: stage_if
// PURPOSE
//  Instruction-fetch stage: producer end of the IF->ID interface (pc/inst/valid) and consumer of ID's branch redirect.
//  Fetches 32-bit instructions over the shared byte-wide memory port (1-cycle read latency), assembles them
//  little-endian and presents them in a one-entry output buffer to if_id. Arbitration: request/grant to memory controller.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  NOP_INST   32'h0000_0013  value on inst_o when no valid instruction (addi x0,x0,0)
// PORTS
//  clk              in   1   single clock, all state on rising edge
//  rst              in   1   asynchronous, active-low reset
//  rdy              in   1   global ready; low = freeze every register (memory controller frozen by same rdy)
//  stall_i          in   1   downstream not accepting; handoff occurs when inst_valid_o && !stall_i
//  branch_enable_i  in   1   redirect request from ID, sampled at clock edge
//  branch_addr_i    in   32  redirect target
//  if_grant_i       in   1   memory port granted; held high by controller while if_req_o high
//  mem_din_i        in   8   read byte for address driven on previous cycle
//  if_req_o         out  1   memory port request
//  mem_a_o          out  32  byte read address
//  pc_o             out  32  address of presented instruction
//  inst_o           out  32  presented instruction
//  inst_valid_o     out  1   output buffer holds a valid instruction
// BEHAVIOUR
//  Reset (rst low, immediate): state=S_IDLE, fetch_pc=RESET_PC, pc_o=0, inst_o=NOP_INST, inst_valid_o=0, byte regs=0.
//  Priority each edge: rst > rdy low (hold all) > branch_enable_i > stall/normal.
//  States: S_IDLE, S_A0, S_A1, S_A2, S_A3, S_LAST, S_HOLD.
//  - S_IDLE: if_req_o=1; if_grant_i -> S_A0, else stay.
//  - S_A0..S_A3: if_req_o=1, mem_a_o=fetch_pc+0/+1/+2/+3; S_A1,S_A2,S_A3 capture mem_din_i as byte0,1,2.
//  - S_LAST: if_req_o=0; byte3=mem_din_i; word={byte3,byte2,byte1,byte0}.
//      buffer free (!inst_valid_o || !stall_i): pc_o<=fetch_pc, inst_o<=word, inst_valid_o<=1,
//      fetch_pc<=fetch_pc+4 (32-bit wrap), -> S_IDLE. Else latch word internally -> S_HOLD.
//  - S_HOLD: if_req_o=0; load buffer as above once free, -> S_IDLE.
//  - mem_a_o = 0 in S_IDLE, S_LAST, S_HOLD.
//  Output buffer: handoff with no new load same edge -> inst_valid_o<=0, inst_o<=NOP_INST; load on handoff edge
//   replaces contents (no bubble). While stall_i high and valid, pc_o/inst_o held stable.
//  Latency: grant sampled in S_IDLE -> inst_valid_o high 5 edges later (unstalled). Throughput 1 inst / 6 cycles.
//  Branch (branch_enable_i=1 at edge, any state): fetch aborted, fetch_pc<=branch_addr_i, state<=S_IDLE,
//   inst_valid_o<=0, inst_o<=NOP_INST (buffer is wrong-path); branch wins over simultaneous load/handoff.
//  branch_addr_i used unmodified (no alignment check); misaligned targets fetched bytewise as given.
//  rdy low: state, fetch_pc, bytes, outputs frozen; resumes exactly where left when rdy returns.
//  Reset mid-fetch: abort immediately, no partial instruction ever becomes valid.
// TESTING
//  1 rst low -> inst_valid_o=0, inst_o=32'h13, if_req_o=0; release, grant=1, mem[0..3]=93 00 10 00 ->
//    5 edges after S_IDLE grant: inst_valid_o=1, inst_o=32'h00100093, pc_o=0.
//  2 Back-to-back, stall_i=0, mem[4..7]=13 01 20 00 -> next valid pc_o=4, inst_o=32'h00200113, mem_a_o 4,5,6,7.
//  3 stall_i=1 from first valid -> pc_o=0 held, second fetch parks in S_HOLD, if_req_o=0; stall_i=0 ->
//    next edge pc_o=4 loaded, inst_valid_o stays 1.
//  4 branch_enable_i=1, branch_addr_i=32'h100 during S_A2 -> next edge inst_valid_o=0; mem_a_o then
//    100..103; next valid pc_o=32'h100.
//  5 if_grant_i=0 for 10 cycles -> stays S_IDLE, if_req_o=1, mem_a_o=0, no valid; grant=1 -> fetch proceeds.
//  6 rdy=0 for 3 cycles in S_A2 / rst low in S_A2 -> freeze with correct word after resume / reset values instantly.

Source files
------------

// File: rtl/stage_if.sv
// Instruction-fetch stage: assembles 32-bit little-endian instructions from a byte-wide
// memory port and presents them to decode through a one-entry output buffer.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_addr_i,
  input  logic        if_grant_i,
  input  logic [7:0]  mem_din_i,
  output logic        if_req_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_A0,
    S_A1,
    S_A2,
    S_A3,
    S_LAST,
    S_HOLD
  } state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic [7:0]  byte_reg [0:3];

  logic [31:0] word_last;
  logic [31:0] word_held;
  logic        buffer_free;
  logic        handoff;

  // In S_LAST the top byte is still on the bus; in S_HOLD it has been latched.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_word
      assign word_last[8*gi +: 8] = byte_reg[gi];
      assign word_held[8*gi +: 8] = byte_reg[gi];
    end
  endgenerate
  assign word_last[31:24] = mem_din_i;
  assign word_held[31:24] = byte_reg[3];

  assign buffer_free = !inst_valid_o || !stall_i;
  assign handoff     = inst_valid_o && !stall_i;

  // Request is held low while reset is asserted even though the state is S_IDLE.
  always_comb begin
    if_req_o = 1'b0;
    mem_a_o  = 32'h0;
    if (rst) begin
      case (state_reg)
        S_IDLE: if_req_o = 1'b1;
        S_A0: begin
          if_req_o = 1'b1;
          mem_a_o  = fetch_pc_reg;
        end
        S_A1: begin
          if_req_o = 1'b1;
          mem_a_o  = fetch_pc_reg + 32'd1;
        end
        S_A2: begin
          if_req_o = 1'b1;
          mem_a_o  = fetch_pc_reg + 32'd2;
        end
        S_A3: begin
          if_req_o = 1'b1;
          mem_a_o  = fetch_pc_reg + 32'd3;
        end
        default: begin
          if_req_o = 1'b0;
          mem_a_o  = 32'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      pc_o         <= 32'h0;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        byte_reg[i] <= 8'h0;
      end
    end else if (rdy) begin
      if (branch_enable_i) begin
        // Buffer content is wrong-path; drop it along with any partial fetch.
        state_reg    <= S_IDLE;
        fetch_pc_reg <= branch_addr_i;
        inst_valid_o <= 1'b0;
        inst_o       <= NOP_INST;
      end else begin
        if (handoff) begin
          inst_valid_o <= 1'b0;
          inst_o       <= NOP_INST;
        end
        case (state_reg)
          S_IDLE: begin
            if (if_grant_i) begin
              state_reg <= S_A0;
            end
          end
          S_A0: state_reg <= S_A1;
          S_A1: begin
            byte_reg[0] <= mem_din_i;
            state_reg   <= S_A2;
          end
          S_A2: begin
            byte_reg[1] <= mem_din_i;
            state_reg   <= S_A3;
          end
          S_A3: begin
            byte_reg[2] <= mem_din_i;
            state_reg   <= S_LAST;
          end
          S_LAST: begin
            byte_reg[3] <= mem_din_i;
            if (buffer_free) begin
              pc_o         <= fetch_pc_reg;
              inst_o       <= word_last;
              inst_valid_o <= 1'b1;
              fetch_pc_reg <= fetch_pc_reg + 32'd4;
              state_reg    <= S_IDLE;
            end else begin
              state_reg <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (buffer_free) begin
              pc_o         <= fetch_pc_reg;
              inst_o       <= word_held;
              inst_valid_o <= 1'b1;
              fetch_pc_reg <= fetch_pc_reg + 32'd4;
              state_reg    <= S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: byte memory model with one-cycle latency, frozen by rdy.
module tb_stage_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall_i;
  logic        branch_enable_i;
  logic [31:0] branch_addr_i;
  logic        if_grant_i;
  logic [7:0]  mem_din_i = 8'h0;
  logic        if_req_o;
  logic [31:0] mem_a_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [0:511];

  stage_if dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .stall_i         (stall_i),
    .branch_enable_i (branch_enable_i),
    .branch_addr_i   (branch_addr_i),
    .if_grant_i      (if_grant_i),
    .mem_din_i       (mem_din_i),
    .if_req_o        (if_req_o),
    .mem_a_o         (mem_a_o),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdy) mem_din_i <= mem[mem_a_o[8:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-10s %h", tag, got);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;
    mem[4] = 8'h13; mem[5] = 8'h01; mem[6] = 8'h20; mem[7] = 8'h00;
    mem[256] = 8'hb7; mem[257] = 8'h12; mem[258] = 8'h34; mem[259] = 8'h00;

    rst = 1'b0; rdy = 1'b1; stall_i = 1'b0; branch_enable_i = 1'b0;
    branch_addr_i = 32'h0; if_grant_i = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, 32'h13);
    check("rst_req", 32'(if_req_o), 32'd0);
    rst = 1'b1;

    // no grant: request held, nothing fetched
    for (int k = 0; k < 10; k++) begin
      tick();
      check("ng_req", 32'(if_req_o), 32'd1);
      check("ng_addr", mem_a_o, 32'h0);
      check("ng_valid", 32'(inst_valid_o), 32'd0);
    end

    if_grant_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("f0_addr", mem_a_o, 32'(k));
    end
    tick();
    check("last_req", 32'(if_req_o), 32'd0);
    tick();
    check("f0_valid", 32'(inst_valid_o), 32'd1);
    check("f0_inst", inst_o, 32'h00100093);
    check("f0_pc", pc_o, 32'h0);
    check("idle_req", 32'(if_req_o), 32'd1);

    // back-to-back, first instruction handed off on next edge
    tick();
    check("hand_vld", 32'(inst_valid_o), 32'd0);
    check("hand_inst", inst_o, 32'h13);
    check("f1_addr", mem_a_o, 32'h4);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("f1_addr", mem_a_o, 32'(4 + k));
    end
    repeat (2) tick();
    check("f1_valid", 32'(inst_valid_o), 32'd1);
    check("f1_inst", inst_o, 32'h00200113);
    check("f1_pc", pc_o, 32'h4);

    // stall: next word parks in S_HOLD
    stall_i = 1'b1;
    repeat (6) tick();
    check("hold_req", 32'(if_req_o), 32'd0);
    check("hold_pc", pc_o, 32'h4);
    check("hold_inst", inst_o, 32'h00200113);
    check("hold_vld", 32'(inst_valid_o), 32'd1);
    tick();
    check("hold_pc2", pc_o, 32'h4);
    check("hold_req2", 32'(if_req_o), 32'd0);
    stall_i = 1'b0;
    tick();
    check("f2_valid", 32'(inst_valid_o), 32'd1);
    check("f2_pc", pc_o, 32'h8);
    check("f2_inst", inst_o, 32'h0b0a0908);

    // branch during S_A2 while buffer is stalled full
    stall_i = 1'b1;
    repeat (3) tick();
    check("a2_addr", mem_a_o, 32'hE);
    check("a2_pc", pc_o, 32'h8);
    branch_enable_i = 1'b1;
    branch_addr_i   = 32'h100;
    tick();
    check("br_valid", 32'(inst_valid_o), 32'd0);
    check("br_inst", inst_o, 32'h13);
    check("br_addr", mem_a_o, 32'h0);
    check("br_req", 32'(if_req_o), 32'd1);
    branch_enable_i = 1'b0;
    stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("br_faddr", mem_a_o, 32'(32'h100 + k));
    end
    repeat (2) tick();
    check("br_fvalid", 32'(inst_valid_o), 32'd1);
    check("br_fpc", pc_o, 32'h100);
    check("br_finst", inst_o, 32'h003412b7);

    // rdy low for 3 cycles in S_A2
    repeat (3) tick();
    check("rdy_a2", mem_a_o, 32'h106);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("frz_addr", mem_a_o, 32'h106);
    end
    rdy = 1'b1;
    tick();
    check("res_addr", mem_a_o, 32'h107);
    repeat (2) tick();
    check("res_valid", 32'(inst_valid_o), 32'd1);
    check("res_pc", pc_o, 32'h104);
    check("res_inst", inst_o, 32'h07060504);

    // reset in S_A2 takes effect without a clock edge
    repeat (3) tick();
    check("pre_rst", mem_a_o, 32'h10A);
    rst = 1'b0;
    #1;
    check("mr_valid", 32'(inst_valid_o), 32'd0);
    check("mr_inst", inst_o, 32'h13);
    check("mr_req", 32'(if_req_o), 32'd0);
    check("mr_pc", pc_o, 32'h0);
    check("mr_addr", mem_a_o, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();
    check("rr_valid", 32'(inst_valid_o), 32'd1);
    check("rr_pc", pc_o, 32'h0);
    check("rr_inst", inst_o, 32'h00100093);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
